// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
//   Shared definitions for the MUL/DIV sequencer:
//   - INST_* opcode encodings seen on req_inst / dp_inst (INST_NOP = idle)
//   - STATE_* controller state encoding
//   - opcode classification helpers
//   Build option: MULDIV_ACCUM_EN makes MADD/MADDU/MSUB/MSUBU supported ops.
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

  localparam logic [7:0] INST_NOP   = 8'h00;
  localparam logic [7:0] INST_MULT  = 8'h18;
  localparam logic [7:0] INST_MULTU = 8'h19;
  localparam logic [7:0] INST_DIV   = 8'h1A;
  localparam logic [7:0] INST_DIVU  = 8'h1B;
  localparam logic [7:0] INST_MADD  = 8'h1C;
  localparam logic [7:0] INST_MADDU = 8'h1D;
  localparam logic [7:0] INST_MSUB  = 8'h1E;
  localparam logic [7:0] INST_MSUBU = 8'h1F;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_RUN  = 2'd1,
    STATE_ACC  = 2'd2,
    STATE_WB   = 2'd3
  } state_e;

  // Multiply-accumulate family (adds or subtracts the product into HI/LO)
  function automatic logic is_accum_op(input logic [7:0] inst);
    return (inst == INST_MADD) || (inst == INST_MADDU) ||
           (inst == INST_MSUB) || (inst == INST_MSUBU);
  endfunction

  function automatic logic is_sub_op(input logic [7:0] inst);
    return (inst == INST_MSUB) || (inst == INST_MSUBU);
  endfunction

  // Opcodes the controller will accept in this build
  function automatic logic is_supported(input logic [7:0] inst);
    logic ok;
    ok = (inst == INST_MULT) || (inst == INST_MULTU) ||
         (inst == INST_DIV)  || (inst == INST_DIVU);
`ifdef MULDIV_ACCUM_EN
    ok = ok | is_accum_op(inst);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_if
//   Request handshake from EX plus the bus to the multi-cycle MUL/DIV datapath.
//   Request side : req_valid, req_inst[7:0], req_op1[31:0], req_op2[31:0] -> ;
//                  req_ready <-
//   Datapath side: dp_inst[7:0], dp_op1/dp_op2[31:0], dp_hilo[63:0] -> ;
//                  dp_result[63:0], dp_done <-
//   modport master : EX stage + datapath environment
//   modport slave  : the muldiv_ctrl sequencer
// -----------------------------------------------------------------------------
interface muldiv_ctrl_if;
  logic        req_valid;
  logic [7:0]  req_inst;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic        req_ready;
  logic [7:0]  dp_inst;
  logic [31:0] dp_op1;
  logic [31:0] dp_op2;
  logic [63:0] dp_hilo;
  logic [63:0] dp_result;
  logic        dp_done;

  modport master (
    output req_valid, req_inst, req_op1, req_op2, dp_result, dp_done,
    input  req_ready, dp_inst, dp_op1, dp_op2, dp_hilo
  );

  modport slave (
    input  req_valid, req_inst, req_op1, req_op2, dp_result, dp_done,
    output req_ready, dp_inst, dp_op1, dp_op2, dp_hilo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//   Sequencer between EX and the multi-cycle MUL/DIV datapath. Accepts one
//   HI/LO-writing op at a time, holds opcode/operands stable until dp_done,
//   then writes the 64-bit {hi,lo} result with a one-cycle strobe.
//   Build option: MULDIV_ACCUM_EN enables MADD*/MSUB* via an ACC state that
//   adds/subtracts the product to the HI/LO snapshot taken at accept.
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   bus           muldiv_ctrl_if.slave (request handshake + datapath bus)
//   flush         exception flush, aborts any in-flight op
//   hilo_rd_req   EX executes MFHI/MFLO/MTHI/MTLO this cycle
//   stall         freeze IF..EX
//   hilo_i        architectural HI/LO
//   hilo_we       one-cycle HI/LO write strobe, hilo_wdata = {hi,lo}
//   busy          op in flight
//   wdog_err      one-cycle pulse, registered, in the cycle after a
//                 watchdog abort (controller already back in IDLE)
// -----------------------------------------------------------------------------
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WDOG_CYCLES = 40,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_ctrl_if.slave bus,
  input  logic        flush,
  input  logic        hilo_rd_req,
  output logic        stall,
  input  logic [63:0] hilo_i,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata,
  output logic        busy,
  output logic        wdog_err
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [7:0]         r_inst;
  logic [31:0]        r_op1;
  logic [31:0]        r_op2;
  logic [63:0]        r_result;
  logic [CNT_W-1:0]   r_wdog;
  logic               r_wdog_err;
  logic               w_supported;
  logic               w_accept;
  logic               w_wdog_hit;

`ifdef MULDIV_ACCUM_EN
  logic [63:0]        r_hilo;

  // 64-bit wrap-around accumulate of the product into the HI/LO snapshot
  function automatic logic [63:0] accum(input logic [63:0] acc,
                                        input logic [63:0] prod,
                                        input logic        sub);
    return sub ? (acc - prod) : (acc + prod);
  endfunction
`else
  logic               w_unused_hilo;
  assign w_unused_hilo = ^hilo_i;
`endif

  assign w_supported   = is_supported(bus.req_inst);
  assign bus.req_ready = (r_state == STATE_IDLE) & ~flush;
  assign w_accept      = bus.req_valid & bus.req_ready & w_supported;
  // Counter holds the number of RUN cycles already spent, so hitting
  // WDOG_CYCLES-1 here means this is the last allowed RUN cycle.
  assign w_wdog_hit    = (r_state == STATE_RUN) & ~bus.dp_done &
                         (r_wdog == CNT_W'(WDOG_CYCLES - 1));

  assign busy       = (r_state != STATE_IDLE);
  assign hilo_we    = (r_state == STATE_WB) & ~flush;
  assign hilo_wdata = r_result;
  assign wdog_err   = r_wdog_err;
  // Unsupported opcodes never stall: EX raises reserved-instruction instead.
  assign stall      = (bus.req_valid & w_supported & ~bus.req_ready) |
                      (hilo_rd_req & busy);

  assign bus.dp_inst = r_inst;
  assign bus.dp_op1  = r_op1;
  assign bus.dp_op2  = r_op2;
`ifdef MULDIV_ACCUM_EN
  assign bus.dp_hilo = r_hilo;
`else
  assign bus.dp_hilo = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= STATE_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      STATE_IDLE: if (w_accept) w_state_nxt = STATE_RUN;
      STATE_RUN: begin
        if (bus.dp_done) begin
`ifdef MULDIV_ACCUM_EN
          w_state_nxt = is_accum_op(r_inst) ? STATE_ACC : STATE_WB;
`else
          w_state_nxt = STATE_WB;
`endif
        end else if (w_wdog_hit) begin
          w_state_nxt = STATE_IDLE;
        end
      end
`ifdef MULDIV_ACCUM_EN
      STATE_ACC:  w_state_nxt = STATE_WB;
`endif
      STATE_WB:   w_state_nxt = STATE_IDLE;
      default:    w_state_nxt = STATE_IDLE;
    endcase
    // flush overrides dp_done, the accumulate step and the write-back
    if (flush) w_state_nxt = STATE_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst     <= INST_NOP;
      r_op1      <= '0;
      r_op2      <= '0;
      r_result   <= '0;
      r_wdog     <= '0;
      r_wdog_err <= 1'b0;
`ifdef MULDIV_ACCUM_EN
      r_hilo     <= '0;
`endif
    end else begin
      r_wdog_err <= w_wdog_hit & ~flush;
      if (w_accept) begin
        r_inst <= bus.req_inst;
        r_op1  <= bus.req_op1;
        r_op2  <= bus.req_op2;
        r_wdog <= '0;
`ifdef MULDIV_ACCUM_EN
        r_hilo <= hilo_i;
`endif
      end else if (w_state_nxt == STATE_IDLE) begin
        r_inst <= INST_NOP;
        r_wdog <= '0;
      end else if (r_state == STATE_RUN) begin
        r_wdog <= r_wdog + CNT_W'(1);
      end

      if ((r_state == STATE_RUN) && bus.dp_done && !flush)
        r_result <= bus.dp_result;
`ifdef MULDIV_ACCUM_EN
      if ((r_state == STATE_ACC) && !flush)
        r_result <= accum(r_hilo, r_result, is_sub_op(r_inst));
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int DIV_LAT = 37;   // RUN cycles the modelled divider needs

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        hilo_rd_req = 1'b0;
  logic        stall, hilo_we, busy, wdog_err;
  logic [63:0] hilo_i, hilo_wdata;
  logic [63:0] hilo_reg = '0;
  bit          preset_en = 1'b0;
  logic [63:0] preset_val = '0;
  bit          dp_hang = 1'b0;
  int          dp_cnt = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct { logic [63:0] data; int cyc; } exp_t;
  exp_t exp_q[$];

  muldiv_ctrl_if bus();

  muldiv_ctrl #(.WDOG_CYCLES(40), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
    .hilo_rd_req(hilo_rd_req), .stall(stall), .hilo_i(hilo_i),
    .hilo_we(hilo_we), .hilo_wdata(hilo_wdata), .busy(busy),
    .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Architectural HI/LO register
  assign hilo_i = hilo_reg;
  always @(posedge clk) begin
    if (preset_en)    hilo_reg <= preset_val;
    else if (hilo_we) hilo_reg <= hilo_wdata;
  end

  // Raw datapath arithmetic: product or {remainder, quotient}
  function automatic logic [63:0] raw_op(input logic [7:0] inst, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    int si, ti, q, r;
    logic [31:0] lq, lr;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    si = a; ti = b;
    case (inst)
      INST_MULT, INST_MADD, INST_MSUB:    return sa * sb;
      INST_MULTU, INST_MADDU, INST_MSUBU: return ua * ub;
      INST_DIV:  begin q = si / ti; r = si % ti; lq = q; lr = r; return {lr, lq}; end
      INST_DIVU: begin lq = a / b; lr = a % b; return {lr, lq}; end
      default:   return '0;
    endcase
  endfunction

  // Reference: what must land in HI/LO, given HI/LO at accept
  function automatic logic [63:0] ref_model(input logic [7:0] inst, input logic [31:0] a, input logic [31:0] b, input logic [63:0] hilo);
    logic [63:0] p;
    p = raw_op(inst, a, b);
    if (inst == INST_MADD || inst == INST_MADDU) return hilo + p;
    if (inst == INST_MSUB || inst == INST_MSUBU) return hilo - p;
    return p;
  endfunction

  // Cycles from accept to the hilo_we cycle
  function automatic int wr_ofs(input logic [7:0] inst);
    if (inst == INST_DIV || inst == INST_DIVU) return DIV_LAT + 1;
    if (inst inside {INST_MADD, INST_MADDU, INST_MSUB, INST_MSUBU}) return 3;
    return 2;
  endfunction

  // Datapath model: dp_done combinational on the held opcode
  always @(posedge clk) dp_cnt <= (bus.dp_inst == INST_NOP) ? 0 : dp_cnt + 1;
  always_comb begin
    bus.dp_done   = 1'b0;
    bus.dp_result = '0;
    if (bus.dp_inst != INST_NOP && !dp_hang &&
        dp_cnt == (((bus.dp_inst == INST_DIV) || (bus.dp_inst == INST_DIVU)) ? DIV_LAT - 1 : 0)) begin
      bus.dp_done   = 1'b1;
      bus.dp_result = raw_op(bus.dp_inst, bus.dp_op1, bus.dp_op2);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && hilo_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got %h expected no write (cycle %0d)", hilo_wdata, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("hilo_wdata", hilo_wdata, e.data);
          chk("write_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  endtask

  // Called just after a posedge; returns just after the posedge following accept
  task automatic issue(input logic [7:0] inst, input logic [31:0] a, input logic [31:0] b,
                       input bit exp_wr, input logic [63:0] exp_val, output int acc_cyc);
    bus.req_valid = 1'b1; bus.req_inst = inst; bus.req_op1 = a; bus.req_op2 = b;
    acc_cyc = -1;
    for (int i = 0; i < 200 && acc_cyc < 0; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        acc_cyc = cyc;
        chk("stall_accept_cycle", stall, 64'd0);
        if (exp_wr) exp_q.push_back('{exp_val, cyc + wr_ofs(inst)});
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0; bus.req_inst = INST_NOP;
    if (acc_cyc < 0) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy expected idle within 100 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic preset(input logic [63:0] v);
    preset_val = v; preset_en = 1'b1;
    @(posedge clk); #1;
    preset_en = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, t2, n, w;
    logic [63:0] ref_hilo, e;
    logic [7:0] ops [8];
    int nops;
    logic [7:0] op;
    logic [31:0] a, b;

    ops = '{INST_MULT, INST_MULTU, INST_DIV, INST_DIVU, INST_MADD, INST_MADDU, INST_MSUB, INST_MSUBU};
`ifdef MULDIV_ACCUM_EN
    nops = 8;
`else
    nops = 4;
`endif
    bus.req_valid = 1'b0; bus.req_inst = INST_NOP; bus.req_op1 = '0; bus.req_op2 = '0;
    fork monitor(); join_none

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_hilo_we", hilo_we, 0);
    chk("rst_wdog_err", wdog_err, 0);
    chk("rst_dp_inst", bus.dp_inst, INST_NOP);
    chk("rst_dp_op1", bus.dp_op1, 0);
    chk("rst_dp_op2", bus.dp_op2, 0);
    chk("rst_dp_hilo", bus.dp_hilo, 0);
    chk("rst_hilo_wdata", hilo_wdata, 0);
    chk("rst_stall", stall, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // MULTU: write at accept+2, never stalls
    issue(INST_MULTU, 32'hFFFFFFFF, 32'd2, 1'b1, 64'h1_FFFFFFFE, t);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("multu_no_stall", stall, 0);
    end
    @(posedge clk); #1;

    // DIV 100,7: busy for 38 cycles
    issue(INST_DIV, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14}, t);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy === 1'b1) n++; else break;
    end
    chk("div_busy_cycles", 64'(n), 64'd38);
    @(posedge clk); #1;
    issue(INST_DIV, -32'sd100, 32'd7, 1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, t);
    wait_idle();

    // HI/LO hazard: MFLO and a second MULT stall through WB inclusive
    issue(INST_DIV, 32'd1000, 32'd10, 1'b1, {32'd0, 32'd100}, t);
    repeat (4) @(posedge clk);
    #1;
    hilo_rd_req = 1'b1;
    bus.req_valid = 1'b1; bus.req_inst = INST_MULT; bus.req_op1 = 32'd6; bus.req_op2 = 32'd7;
    for (int k = 5; k <= DIV_LAT + 2; k++) begin
      @(negedge clk);
      chk("hazard_stall", stall, (k <= DIV_LAT + 1) ? 64'd1 : 64'd0);
      if (k == DIV_LAT + 2) begin
        chk("hazard_ready_after_wb", bus.req_ready, 1);
        exp_q.push_back('{64'd42, cyc + 2});
      end
      @(posedge clk); #1;
    end
    hilo_rd_req = 1'b0; bus.req_valid = 1'b0; bus.req_inst = INST_NOP;
    wait_idle();

    // flush at accept+10 of DIV 9,3
    issue(INST_DIV, 32'd9, 32'd3, 1'b0, '0, t);
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_idle", busy, 0);
    chk("flush_dp_nop", bus.dp_inst, INST_NOP);
    issue(INST_MULT, 32'hFFFFFFFF, 32'd5, 1'b1, 64'hFFFFFFFF_FFFFFFFB, t2);
    chk("flush_reaccept_cycle", 64'(t2), 64'(t + 11));
    wait_idle();

    // Watchdog: datapath never answers
    dp_hang = 1'b1;
    issue(INST_MULT, 32'd2, 32'd3, 1'b0, '0, t);
    w = -1;
    for (int k = 0; k < 100 && w < 0; k++) begin
      @(negedge clk);
      if (wdog_err === 1'b1) begin
        w = cyc;
        chk("wdog_idle", busy, 0);
      end
    end
    chk("wdog_cycle", 64'(w), 64'(t + 41));
    @(negedge clk); chk("wdog_one_pulse", wdog_err, 0);
    dp_hang = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset mid-operation
    issue(INST_DIV, 32'd5, 32'd1, 1'b0, '0, t);
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_dp_inst", bus.dp_inst, INST_NOP);
    chk("arst_dp_op1", bus.dp_op1, 0);
    @(negedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef MULDIV_ACCUM_EN
    preset(64'h5);
    issue(INST_MADD, 32'd3, 32'd4, 1'b1, 64'h11, t);
    chk("madd_dp_hilo", bus.dp_hilo, 64'h5);
    wait_idle();
    preset(64'h0);
    issue(INST_MSUB, 32'd1, 32'd6, 1'b1, 64'hFFFFFFFF_FFFFFFFA, t);
    wait_idle();
`else
    // MADD unsupported: never accepted, never stalls
    bus.req_valid = 1'b1; bus.req_inst = INST_MADD; bus.req_op1 = 32'd3; bus.req_op2 = 32'd4;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("madd_not_busy", busy, 0);
      chk("madd_no_stall", stall, 0);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0; bus.req_inst = INST_NOP;
`endif

    // Randomized back-to-back traffic against the reference model
    ref_hilo = {$urandom, $urandom};
    preset(ref_hilo);
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, nops - 1)];
      a = $urandom; b = $urandom;
      if (b == 0) b = 32'd1;
      if (op == INST_DIV && b == 32'hFFFFFFFF) b = 32'd3;
      e = ref_model(op, a, b, ref_hilo);
      ref_hilo = e;
      issue(op, a, b, 1'b1, e, t);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("pending_writes", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
